// File: rtl/fifo_sync_cfg_if.sv
// Handshake, data and status bundle for fifo_sync_cfg.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface fifo_sync_cfg_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  i_wr;
  logic [DATA_WIDTH-1:0] i_din;
  logic                  i_rd;
  logic                  i_flush;
  logic                  i_clr_err;
  logic [DATA_WIDTH-1:0] o_dout;
  logic                  o_valid;
  logic                  o_empty;
  logic                  o_almost_empty;
  logic                  o_almost_full;
  logic                  o_full;
  logic [ADDR_WIDTH:0]   o_fill;
  logic                  o_overrun;
  logic                  o_underrun;

  modport master (
    output i_wr, i_din, i_rd, i_flush, i_clr_err,
    input  o_dout, o_valid, o_empty, o_almost_empty, o_almost_full, o_full,
           o_fill, o_overrun, o_underrun
  );

  modport slave (
    input  i_wr, i_din, i_rd, i_flush, i_clr_err,
    output o_dout, o_valid, o_empty, o_almost_empty, o_almost_full, o_full,
           o_fill, o_overrun, o_underrun
  );
endinterface

// File: rtl/fifo_sync_cfg.sv
// Synchronous FIFO with configurable depth and thresholds, sticky overrun/underrun flags,
// flush, and either a registered read port (FWFT=0) or first-word-fall-through (FWFT=1).
module fifo_sync_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = (2**ADDR_WIDTH) - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  fifo_sync_cfg_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   C_FILL_ZERO = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0]   C_FILL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   C_FILL_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_FILL_AF   = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   C_FILL_AE   = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ZERO  = (ADDR_WIDTH)'(0);
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE   = (ADDR_WIDTH)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_fill;
  logic                  r_overrun;
  logic                  r_underrun;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_ovr_evt;
  logic                  w_und_evt;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_empty   = (r_fill == C_FILL_ZERO);
  assign w_full    = (r_fill == C_FILL_FULL);
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign w_rd_ok   = bus.i_rd & ~w_empty;
  assign w_wr_ok   = bus.i_wr & (~w_full | w_rd_ok);
  assign w_ovr_evt = ~bus.i_flush & bus.i_wr & ~w_wr_ok;
  assign w_und_evt = ~bus.i_flush & bus.i_rd & w_empty;
  assign w_rd_word = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst && !bus.i_flush && w_wr_ok) begin
      r_mem[r_wr_ptr] <= bus.i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= C_PTR_ZERO;
      r_rd_ptr   <= C_PTR_ZERO;
      r_fill     <= C_FILL_ZERO;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (bus.i_flush) begin
        r_wr_ptr <= C_PTR_ZERO;
        r_rd_ptr <= C_PTR_ZERO;
        r_fill   <= C_FILL_ZERO;
      end else begin
        if (w_wr_ok) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        if (w_rd_ok) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        case ({w_wr_ok, w_rd_ok})
          2'b10:   r_fill <= r_fill + C_FILL_ONE;
          2'b01:   r_fill <= r_fill - C_FILL_ONE;
          default: r_fill <= r_fill;
        endcase
      end
      // A fresh error wins over a clear arriving in the same cycle.
      r_overrun  <= w_ovr_evt | (r_overrun  & ~bus.i_clr_err);
      r_underrun <= w_und_evt | (r_underrun & ~bus.i_clr_err);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.o_dout  = w_rd_word;
      assign bus.o_valid = ~w_empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_valid;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_dout  <= {DATA_WIDTH{1'b0}};
          r_valid <= 1'b0;
        end else if (bus.i_flush) begin
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rd_ok;
          if (w_rd_ok) r_dout <= w_rd_word;
        end
      end

      assign bus.o_dout  = r_dout;
      assign bus.o_valid = r_valid;
    end
  endgenerate

  assign bus.o_empty        = w_empty;
  assign bus.o_full         = w_full;
  assign bus.o_almost_full  = (r_fill >= C_FILL_AF);
  assign bus.o_almost_empty = (r_fill <= C_FILL_AE);
  assign bus.o_fill         = r_fill;
  assign bus.o_overrun      = r_overrun;
  assign bus.o_underrun     = r_underrun;
endmodule

// File: doc/fifo_sync_cfg.md
FIFO_SYNC_CFG -- requirements
Module: fifo_sync_cfg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-1: almost-full level, legal range 1..DEPTH.
REQ-004 SHALL have parameter AE_THRESH, default 1: almost-empty level, legal range 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0: read mode, 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL use one clock and a synchronous, active-high reset; all state changes on the i_clk rising edge.
REQ-007 SHALL have port i_clk, input, 1 bit: clock.
REQ-008 SHALL have port i_rst, input, 1 bit: synchronous reset, active high.
REQ-009 SHALL have port i_wr, input, 1 bit: write request.
REQ-010 SHALL have port i_din, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port i_rd, input, 1 bit: read/pop request.
REQ-012 SHALL have port o_dout, output, DATA_WIDTH bits: read data.
REQ-013 SHALL have port o_valid, output, 1 bit: o_dout holds valid data.
REQ-014 SHALL have port i_flush, input, 1 bit: discard all contents.
REQ-015 SHALL have port i_clr_err, input, 1 bit: clear sticky error flags.
REQ-016 SHALL have outputs o_empty, o_almost_empty, o_almost_full and o_full, 1 bit each: status flags.
REQ-017 SHALL have port o_fill, output, ADDR_WIDTH+1 bits: stored word count, 0..DEPTH.
REQ-018 SHALL have outputs o_overrun and o_underrun, 1 bit each: sticky error flags.

Function
REQ-019 SHALL accept a write when i_wr=1 and (fill<DEPTH or an accepted read in the same cycle); the word is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-020 SHALL accept a read when i_rd=1 and fill>0; rd_ptr increments modulo DEPTH.
REQ-021 SHALL update fill as: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-022 SHALL, with simultaneous i_rd and i_wr while full, accept both, leave fill=DEPTH and keep o_full=1.
REQ-023 SHALL, with simultaneous i_rd and i_wr while empty, accept the write, reject the read, set o_underrun and make fill=1.
REQ-024 SHALL, on i_wr while full without an accepted read, drop the data, leave memory and pointers unchanged, and set o_overrun at the next edge.
REQ-025 SHALL, on i_rd while empty, leave pointers unchanged and set o_underrun at the next edge.
REQ-026 SHALL hold o_overrun and o_underrun at 1 until i_clr_err=1 or i_rst=1; if i_clr_err and a new error occur in the same cycle, the flag SHALL stay 1.
REQ-027 SHALL decode flags combinationally from the fill register: o_empty = (fill==0), o_full = (fill==DEPTH), o_almost_full = (fill>=AF_THRESH), o_almost_empty = (fill<=AE_THRESH).
REQ-028 SHALL, in FWFT=0 mode, register o_dout from mem[rd_ptr] on an accepted read, with o_valid=1 for exactly the following cycle; o_dout SHALL hold its last value otherwise.
REQ-029 SHALL, in FWFT=1 mode, drive o_dout = mem[rd_ptr] with o_valid = !o_empty; the first write becomes visible on o_dout and o_valid one cycle after acceptance; i_rd pops the displayed word.
REQ-030 SHALL, on i_flush=1, set pointers and fill to 0 at the next edge; i_flush overrides i_wr and i_rd in that cycle, leaves sticky flags unchanged, and forces o_valid=0 at the next edge.

Reset
REQ-031 SHALL, on i_rst=1, set wr_ptr=0, rd_ptr=0, fill=0, o_dout=0, o_valid=0, o_overrun=0, o_underrun=0, o_empty=1, o_full=0, o_almost_full=0 (AF_THRESH>=1) and o_almost_empty=1.
REQ-032 SHALL let i_rst override i_flush, i_wr, i_rd and i_clr_err; memory contents need not be cleared.
REQ-033 SHALL, when i_rst asserts mid-operation, discard all contents; a read on the cycle after release SHALL set o_underrun.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3, AF_THRESH=6, AE_THRESH=1)
REQ-034 SHALL verify basic ordering: write 0xA5 then 0x3C, then read twice (FWFT=0) -> o_dout=0xA5 then 0x3C, each with a one-cycle o_valid pulse; o_empty=1 afterwards.
REQ-035 SHALL verify fill and flags: write 8 words -> o_almost_full rises at fill=6 and o_full at fill=8; a 9th write sets o_overrun with fill still 8; 8 reads return the original 8 words in order.
REQ-036 SHALL verify simultaneous access when full: issue rd+wr for 4 cycles while full -> fill stays 8 and o_full stays 1; the output stream is the old words followed by the new ones in order.
REQ-037 SHALL verify underrun and clear: rd while empty -> o_underrun=1 and o_valid stays 0; pulse i_clr_err -> o_underrun=0 at the next edge.
REQ-038 SHALL verify FWFT=1: write 0x11 -> o_dout=0x11 and o_valid=1 next cycle with no rd; pop -> o_valid=0 and o_empty=1.
REQ-039 SHALL verify flush and reset: write 5 words then i_flush with i_wr=1 -> fill=0 and o_empty=1; write 3 words then i_rst -> fill=0 and all flags at their reset values.
